// File: rtl/sd_cmd_engine_if.sv
// SD command engine <-> SPI master register port.
// The engine drives the bus; the SPI master returns read data.
interface sd_cmd_engine_if;
  logic       spi_cs;
  logic [1:0] spi_addr;
  logic       spi_wr;
  logic       spi_rd;
  logic [7:0] spi_wdata;
  logic [7:0] spi_rdata;

  modport master (
    output spi_cs,
    output spi_addr,
    output spi_wr,
    output spi_rd,
    output spi_wdata,
    input  spi_rdata
  );

  modport slave (
    input  spi_cs,
    input  spi_addr,
    input  spi_wr,
    input  spi_rd,
    input  spi_wdata,
    output spi_rdata
  );
endinterface

// File: rtl/sd_cmd_engine.sv
// SD-over-SPI command engine: sends a 6-byte command, clocks
// out 0xFF filler bytes and polls for the R1 response byte.
module sd_cmd_engine #(
  parameter int NCR_MAX  = 8,
  parameter int POLL_MAX = 1023
) (
  input  logic        pro_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic [7:0]  cmd_crc,
  input  logic [7:0]  spi_ctrl,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic        timeout,
  sd_cmd_engine_if.master spi
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CFG   = 3'd1;
  localparam logic [2:0] SEND  = 3'd2;
  localparam logic [2:0] GUARD = 3'd3;
  localparam logic [2:0] POLL  = 3'd4;
  localparam logic [2:0] READ  = 3'd5;
  localparam logic [2:0] EVAL  = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  localparam logic [3:0] NCR_LIM  = 4'(NCR_MAX);
  localparam logic [9:0] POLL_LIM = 10'(POLL_MAX);

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [9:0]  poll_q, poll_d;
  logic        ph_q, ph_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  r1_q, r1_d;
  logic        to_q, to_d;
  logic        busy_q, busy_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;
  logic [7:0]  crc_q, crc_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        cs, wr, rd;
  logic [7:0]  tx_byte;

  always_comb begin
    case (idx_q)
      4'd0:    tx_byte = {2'b01, cmd_q};
      4'd1:    tx_byte = arg_q[31:24];
      4'd2:    tx_byte = arg_q[23:16];
      4'd3:    tx_byte = arg_q[15:8];
      4'd4:    tx_byte = arg_q[7:0];
      4'd5:    tx_byte = crc_q;
      default: tx_byte = 8'hFF;
    endcase
  end

  // Bus strobes decode straight from state; addr/wdata keep their
  // last driven value between accesses.
  always_comb begin
    cs      = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      state_q == CFG: begin
        cs = 1'b1; wr = 1'b1;
        addr_d = 2'b00; wdata_d = ctrl_q;
      end
      state_q == SEND: begin
        cs = 1'b1; wr = 1'b1;
        addr_d = 2'b10; wdata_d = tx_byte;
      end
      state_q == POLL: begin
        cs = 1'b1; rd = 1'b1; addr_d = 2'b01;
      end
      state_q == READ: begin
        cs = 1'b1; rd = 1'b1; addr_d = 2'b11;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    poll_d  = poll_q;
    ph_d    = ph_q;
    byte_d  = byte_q;
    r1_d    = r1_q;
    to_d    = to_q;
    busy_d  = busy_q;
    cmd_d   = cmd_q;
    arg_d   = arg_q;
    crc_d   = crc_q;
    ctrl_d  = ctrl_q;
    unique case (state_q)
      IDLE: if (start) begin
        cmd_d   = cmd_idx;
        arg_d   = cmd_arg;
        crc_d   = cmd_crc;
        ctrl_d  = spi_ctrl;
        busy_d  = 1'b1;
        to_d    = 1'b0;
        state_d = CFG;
      end
      CFG: begin
        idx_d   = 4'd0;
        state_d = SEND;
      end
      SEND: begin
        ph_d    = 1'b0;
        state_d = GUARD;
      end
      GUARD: begin
        ph_d = 1'b1;
        if (ph_q) begin
          ph_d    = 1'b0;
          poll_d  = 10'd0;
          state_d = POLL;
        end
      end
      POLL: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (spi.spi_rdata[0]) begin
            state_d = READ;
          end else if (poll_q < POLL_LIM) begin
            poll_d = poll_q + 10'd1;
          end else begin
            to_d    = 1'b1;
            r1_d    = 8'hFF;
            state_d = DONE;
          end
        end
      end
      READ: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          byte_d  = spi.spi_rdata;
          state_d = EVAL;
        end
      end
      EVAL: begin
        // Bytes 0..5 echo the command frame and carry no response.
        if (idx_q < 4'd6) begin
          idx_d   = idx_q + 4'd1;
          state_d = SEND;
        end else if (!byte_q[7]) begin
          r1_d    = byte_q;
          to_d    = 1'b0;
          state_d = DONE;
        end else if ((idx_q - 4'd5) < NCR_LIM) begin
          idx_d   = idx_q + 4'd1;
          state_d = SEND;
        end else begin
          to_d    = 1'b1;
          r1_d    = byte_q;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pro_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      poll_q  <= 10'd0;
      ph_q    <= 1'b0;
      byte_q  <= 8'h00;
      r1_q    <= 8'hFF;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
      cmd_q   <= 6'd0;
      arg_q   <= 32'd0;
      crc_q   <= 8'h00;
      ctrl_q  <= 8'h00;
      addr_q  <= 2'b00;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      poll_q  <= poll_d;
      ph_q    <= ph_d;
      byte_q  <= byte_d;
      r1_q    <= r1_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      crc_q   <= crc_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign spi.spi_cs    = cs;
  assign spi.spi_wr    = wr;
  assign spi.spi_rd    = rd;
  assign spi.spi_addr  = addr_d;
  assign spi.spi_wdata = wdata_d;

  assign busy    = busy_q;
  assign done    = (state_q == DONE);
  assign r1      = r1_q;
  assign timeout = to_q;

endmodule
